// File: rtl/event_encoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : enc_pkg                                                    |
// | Shared state encoding, default width and index-width helper.         |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package enc_pkg;

    localparam int c_default_width = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    function automatic int enc_code_w(input int width);
        return $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/event_encoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : event_encoder_if                                         |
// | Input vector and output code handshakes of the event encoder.        |
// | Rev       : 1.0                                                      |
// +----------------------------------------------------------------------+
interface event_encoder_if
    import enc_pkg::*;
#(
    parameter int WIDTH = c_default_width
);
    localparam int CODE_W = enc_code_w(WIDTH);

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_bits;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic              out_last;
    logic              busy;

    modport master (
        output in_valid, in_bits, out_ready,
        input  in_ready, out_valid, out_code, out_last, busy
    );

    modport slave (
        input  in_valid, in_bits, out_ready,
        output in_ready, out_valid, out_code, out_last, busy
    );

endinterface
`default_nettype wire

// File: rtl/event_encoder_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : prio_enc                                                    |
// | Combinational priority encoder; lowest set bit wins by default,      |
// | highest set bit wins when ENC_MSB_FIRST_EN is defined.               |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module prio_enc
    import enc_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    localparam int CODE_W = enc_code_w(WIDTH)
) (
    input  logic [WIDTH-1:0]  vec,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    // Later loop iterations overwrite earlier ones, so scan order sets priority.
    always_comb begin
        idx = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) idx = CODE_W'(i);
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = CODE_W'(i);
        end
`endif
        any = |vec;
    end

endmodule
`default_nettype wire

// File: rtl/event_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : event_encoder                                               |
// | Drains a multi-hot event vector as one binary index per transfer.    |
// | Drain order set by ENC_MSB_FIRST_EN (undefined: lowest bit first).   |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module event_encoder
    import enc_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  wire logic      clk,
    input  wire logic      rst,
    event_encoder_if.slave bus
);

    localparam int CODE_W = enc_code_w(WIDTH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_pending;
    logic [WIDTH-1:0]  w_pending_nxt;
    logic [CODE_W-1:0] w_idx;
    logic              w_any;
    logic              w_last;
    logic              w_drain;
    logic              w_in_ready;
    logic [WIDTH-1:0]  w_bit;

    prio_enc #(
        .WIDTH (WIDTH)
    ) u_prio_enc (
        .vec (r_pending),
        .idx (w_idx),
        .any (w_any)
    );

    assign w_drain    = (r_state == DRAIN);
    assign w_last     = ((r_pending & (r_pending - WIDTH'(1))) == '0);
    assign w_bit      = WIDTH'(1) << w_idx;
    // Accepting on the final transfer lets vectors follow with no bubble.
    assign w_in_ready = !rst && (!w_drain || (bus.out_ready && w_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        case (r_state)
            IDLE: begin
                if (bus.in_valid && w_in_ready && (|bus.in_bits)) begin
                    w_pending_nxt = bus.in_bits;
                    w_state_nxt   = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    w_pending_nxt = r_pending & ~w_bit;
                    if (w_last) begin
                        if (bus.in_valid && (|bus.in_bits)) begin
                            w_pending_nxt = bus.in_bits;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_pending_nxt = '0;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_drain && w_any;
    assign bus.busy      = w_drain;
    assign bus.out_code  = w_drain ? w_idx : '0;
    assign bus.out_last  = w_drain && w_last;

endmodule
`default_nettype wire

// File: tb/tb_event_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_event_encoder                                            |
// | Directed vector table plus hand sequences for the event encoder.     |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_event_encoder;

    localparam int c_width = 8;

    typedef struct {
        logic [c_width-1:0] bits;
        int                 n;
        int                 codes[8];
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    vec_t tbl[5];

    event_encoder_if #(.WIDTH(c_width)) bus ();

    event_encoder #(
        .WIDTH (c_width)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    // Table codes are listed lowest-first; the MSB-first build drains them reversed.
    function automatic int ord(input int k, input int n);
`ifdef ENC_MSB_FIRST_EN
        return n - 1 - k;
`else
        return k;
`endif
    endfunction

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_bits   = v.bits;
        bus.out_ready = 1'b1;
        #1 chk("vec_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_bits  = 8'hA5;
        for (int k = 0; k < v.n; k++) begin
            #1;
            chk("vec_valid", 32'(bus.out_valid), 32'd1);
            chk("vec_code", 32'(bus.out_code), 32'(v.codes[ord(k, v.n)]));
            chk("vec_last", 32'(bus.out_last), (k == v.n - 1) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        #1;
        chk("vec_done_valid", 32'(bus.out_valid), 32'd0);
        chk("vec_done_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        tbl[0] = '{bits: 8'b1010_0100, n: 3, codes: '{2, 5, 7, 0, 0, 0, 0, 0}};
        tbl[1] = '{bits: 8'hFF,        n: 8, codes: '{0, 1, 2, 3, 4, 5, 6, 7}};
        tbl[2] = '{bits: 8'h01,        n: 1, codes: '{0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[3] = '{bits: 8'h80,        n: 1, codes: '{7, 0, 0, 0, 0, 0, 0, 0}};
        tbl[4] = '{bits: 8'b0101_1000, n: 3, codes: '{3, 4, 6, 0, 0, 0, 0, 0}};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_bits   = '0;
        bus.out_ready = 1'b0;

        // Reset then idle
        @(negedge clk);
        #1 chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("rst_in_ready2", 32'(bus.in_ready), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        chk("idle_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_code", 32'(bus.out_code), 32'd0);
        chk("idle_last", 32'(bus.out_last), 32'd0);

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // Backpressure holds code and last stable
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_bits   = 8'b0000_0110;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_code", 32'(bus.out_code), 32'(ord(0, 2) + 1));
            chk("bp_last", 32'(bus.out_last), 32'd0);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_rel_code0", 32'(bus.out_code), 32'(ord(0, 2) + 1));
        chk("bp_rel_last0", 32'(bus.out_last), 32'd0);
        @(negedge clk);
        #1;
        chk("bp_rel_code1", 32'(bus.out_code), 32'(ord(1, 2) + 1));
        chk("bp_rel_last1", 32'(bus.out_last), 32'd1);
        chk("bp_rel_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        #1 chk("bp_done_valid", 32'(bus.out_valid), 32'd0);

        // Back-to-back vectors with in_valid held
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_bits  = 8'h01;
        @(negedge clk);
        bus.in_bits = 8'h80;
        #1;
        chk("b2b_code0", 32'(bus.out_code), 32'd0);
        chk("b2b_last0", 32'(bus.out_last), 32'd1);
        chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("b2b_valid1", 32'(bus.out_valid), 32'd1);
        chk("b2b_code1", 32'(bus.out_code), 32'd7);
        chk("b2b_last1", 32'(bus.out_last), 32'd1);
        @(negedge clk);
        #1 chk("b2b_done", 32'(bus.out_valid), 32'd0);

        // Zero vector is accepted and dropped
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_bits  = 8'h00;
        #1 chk("zero_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("zero_valid", 32'(bus.out_valid), 32'd0);
        chk("zero_busy", 32'(bus.busy), 32'd0);
        chk("zero_in_ready2", 32'(bus.in_ready), 32'd1);

        // Reset in the middle of a full-vector drain
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_bits  = 8'hFF;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("mid_code", 32'(bus.out_code), 32'(ord(k, 8)));
            @(negedge clk);
        end
        rst = 1'b1;
        #1 chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        #1 chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
            chk("post_rst_busy", 32'(bus.busy), 32'd0);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/event_encoder.md
Name: event_encoder

Overview:
- Sequential encoder that converts a multi-hot event vector into a stream of binary indices, one per set bit.
- It is the inverse direction of the team's one-hot decoders: the decoder expands a code into a line, and this block compresses lines back into codes.
- It sits between event or interrupt sources and any consumer that takes one binary code per transfer, using valid/ready on both sides.

Parameters:
- WIDTH, 8, number of event lines; must be at least 2.
- CODE_W, $clog2(WIDTH), width of the output index. It is derived and must not be overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bits is presented.
- in_ready  output  1  block accepts in_bits this cycle.
- in_bits  input  WIDTH  event vector; bit i means event i.
- out_valid  output  1  out_code is valid.
- out_ready  input  1  consumer accepts out_code this cycle.
- out_code  output  CODE_W  binary index of the current event.
- out_last  output  1  out_code is the final code of the current vector.
- busy  output  1  a vector is being drained.

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, pending=0.
  - out_valid=0, out_code=0, out_last=0, busy=0.
  - in_ready=0 while rst is high.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - Accept when in_valid&in_ready.
    - Nonzero in_bits: pending<=in_bits, go to DRAIN.
    - in_bits==0: accepted and dropped, stay in IDLE.
  - DRAIN: busy=1, out_valid=1.
    - out_code = index of lowest set bit of pending.
    - out_last = 1 when pending has exactly one bit set, i.e. (pending & (pending-1))==0.
    - On out_valid&out_ready: clear that bit in pending.
    - If out_last, go to IDLE.
- Latency: the first code is valid the cycle after acceptance. Throughput is one code per cycle while out_ready=1.
- Backpressure: with out_ready=0, out_code and out_last hold stable and pending is unchanged.
- in_ready = IDLE | (DRAIN & out_ready & out_last). This allows back-to-back vectors with no bubble.
  - in_ready therefore has a combinational path from out_ready. This is permitted and documented.
  - There is no combinational path from in_* to out_*.
- Simultaneous events: when the last code transfers and a new nonzero vector is accepted in the same cycle, pending<=in_bits and the state stays DRAIN. A new zero vector in that cycle goes to IDLE.
- in_bits is sampled only on acceptance. Changes at other times are ignored.
- Reset mid-DRAIN: pending is discarded and no further codes are emitted. out_valid is 0 on the cycle after the reset edge.
- Vector with a single set bit: exactly one transfer, with out_last=1.
- All bits set: WIDTH transfers with codes 0..WIDTH-1 in order. out_last is set only on WIDTH-1.

Optional Feature:
- Macro: ENC_MSB_FIRST_EN.
- Defined: drain from the highest set bit downward. out_code is the index of the highest set bit of pending. out_last rule is unchanged.
- Undefined: lowest-first order as specified above (default).

Decomposition:
- Package enc_pkg holds:
  - the state typedef (IDLE, DRAIN);
  - the default WIDTH constant;
  - a function computing CODE_W.
- One natural sub-module, prio_enc:
  - purely combinational, parameterised by WIDTH;
  - inputs: vec[WIDTH]; outputs: idx[CODE_W] and any;
  - direction selected by ENC_MSB_FIRST_EN.
  - event_encoder instantiates it on pending.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0. Expect in_ready=0 during reset and 1 after; out_valid=0, busy=0, out_code=0.
- Sparse vector: accept in_bits=8'b1010_0100 with out_ready=1. Expect codes 2, 5, 7 on three consecutive cycles starting the cycle after accept; out_last only with code 7; then IDLE.
- Backpressure: in_bits=8'b0000_0110, hold out_ready=0 for 4 cycles. Expect out_code=1 held stable with out_last=0; on release expect 1 then 2 (out_last=1).
- Back-to-back: after 8'b0000_0001, present 8'b1000_0000 with in_valid held. Expect it accepted on the out_last transfer cycle and codes 0 then 7 with no idle cycle.
- Zero vector and full vector:
  - in_bits=0: accepted, no output, in_ready stays 1.
  - in_bits=8'hFF: codes 0..7 in order; with ENC_MSB_FIRST_EN defined, 7..0.
- Reset mid-drain: 8'hFF, assert rst after code 2 transfers. Expect out_valid=0 the next cycle and no further codes after reset deasserts.
